// File: rtl/wfg_drive_spi_pkg.sv
// -----------------------------------------------------------------------------
// wfg_drive_spi_pkg
// Shared types and helpers for the SPI drive frame sequencer:
//   - frame sequencer state encoding
//   - frame-size (dff) field encodings
//   - dff_to_bits(): maps the frame-size field to a bit count (8/16/24/32)
// -----------------------------------------------------------------------------
package wfg_drive_spi_pkg;

  localparam int DATA_W  = 32;  // sample word width
  localparam int DIV_W   = 8;   // half-period divider width
  localparam int NBITS_W = 6;   // holds a bit count up to 32
  localparam int EDGE_W  = 7;   // holds an sclk edge count up to 64

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam logic [1:0] DFF_8  = 2'b00;
  localparam logic [1:0] DFF_16 = 2'b01;
  localparam logic [1:0] DFF_24 = 2'b10;
  localparam logic [1:0] DFF_32 = 2'b11;

  function automatic logic [NBITS_W-1:0] dff_to_bits(input logic [1:0] dff);
    logic [NBITS_W-1:0] bits;
    case (dff)
      DFF_8:   bits = 6'd8;
      DFF_16:  bits = 6'd16;
      DFF_24:  bits = 6'd24;
      DFF_32:  bits = 6'd32;
      default: bits = 6'd32;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/wfg_drive_spi_clkdiv.sv
// -----------------------------------------------------------------------------
// wfg_drive_spi_clkdiv
// Loadable half-period down-counter for the SPI serial clock. The counter is
// loaded with the divider when a frame is accepted, counts down while the
// frame runs, and reloads from the latched divider on every expiry, so each
// half-period lasts (div+1) clocks (div=255 gives 256 clocks).
// Ports:
//   i_clk         clock
//   i_rst         synchronous active-high reset
//   i_clr         synchronous clear (frame abort)
//   i_load        load i_load_val (frame acceptance)
//   i_load_val    divider value to load
//   i_run         count enable (frame in progress)
//   i_reload_val  latched divider used on expiry
//   o_tick        half-period expiry, valid while running
// -----------------------------------------------------------------------------
module wfg_drive_spi_clkdiv
  import wfg_drive_spi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_reload_val,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_expired;

  assign w_expired = (r_cnt == '0);
  assign o_tick    = i_run & w_expired & ~i_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run) begin
      r_cnt <= w_expired ? i_reload_val : r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wfg_drive_spi_seq.sv
// -----------------------------------------------------------------------------
// wfg_drive_spi_seq
// SPI drive frame sequencer (CPHA=0). Accepts one sample per start pulse,
// snapshots the SPI configuration at acceptance, and sequences chip-select,
// serial clock and serial data for exactly one frame of 8/16/24/32 bits.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wfg_drive_spi_start_i     single-cycle frame request
//   wfg_axis_tdata_i/tvalid_i sample stream input
//   wfg_axis_tready_o         sample accepted this cycle (combinational)
//   ctrl_en_q_i               channel enable (dropping it aborts a frame)
//   cfg_cpol_q_i              serial clock idle level
//   cfg_dff_q_i               frame size (8/16/24/32)
//   cfg_lsbfirst_q_i          shift LSB first when set
//   cfg_sspol_q_i             chip-select active level
//   clkcfg_div_q_i            half-period = div+1 clocks
//   spi_sclk_o/cs_o/sdo_o     registered SPI pins
//   busy_o                    frame in progress
//   underflow_o / overrun_o   one-cycle error pulses
// -----------------------------------------------------------------------------
module wfg_drive_spi_seq
  import wfg_drive_spi_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wfg_drive_spi_start_i,
  input  logic [DATA_W-1:0] wfg_axis_tdata_i,
  input  logic              wfg_axis_tvalid_i,
  output logic              wfg_axis_tready_o,
  input  logic              ctrl_en_q_i,
  input  logic              cfg_cpol_q_i,
  input  logic [1:0]        cfg_dff_q_i,
  input  logic              cfg_lsbfirst_q_i,
  input  logic              cfg_sspol_q_i,
  input  logic [DIV_W-1:0]  clkcfg_div_q_i,
  output logic              spi_sclk_o,
  output logic              spi_cs_o,
  output logic              spi_sdo_o,
  output logic              busy_o,
  output logic              underflow_o,
  output logic              overrun_o
);

  spi_state_e         r_state;
  logic               r_cs;
  logic               r_sclk;
  logic               r_sdo;
  logic               r_underflow;
  logic               r_overrun;
  logic [EDGE_W-1:0]  r_edges;     // sclk edges emitted so far in this frame

  // Frame snapshot (data path, not reset)
  logic               r_cpol;
  logic               r_sspol;
  logic               r_lsbfirst;
  logic [DIV_W-1:0]   r_div;
  logic [NBITS_W-1:0] r_nbits;
  logic [DATA_W-1:0]  r_shreg;     // bits still to be sent, next one at the shift end

  logic               w_active;
  logic               w_accept;
  logic               w_abort;
  logic               w_tick;
  logic               w_shift;
  logic [NBITS_W-1:0] w_nbits_new;
  logic [NBITS_W-1:0] w_shamt;
  logic [DATA_W-1:0]  w_aligned;
  logic               w_first_bit;
  logic [DATA_W-1:0]  w_rest;
  logic               w_next_bit;
  logic [EDGE_W-1:0]  w_last_edge;

  assign w_active    = (r_state != ST_IDLE);
  assign w_accept    = (r_state == ST_IDLE) & wfg_drive_spi_start_i & ctrl_en_q_i &
                       wfg_axis_tvalid_i & ~wb_rst_i;
  assign w_abort     = w_active & ~ctrl_en_q_i;

  // MSB-first frames are left-aligned so the first bit always sits at bit 31
  assign w_nbits_new = dff_to_bits(cfg_dff_q_i);
  assign w_shamt     = 6'd32 - w_nbits_new;
  assign w_aligned   = wfg_axis_tdata_i << w_shamt;
  assign w_first_bit = cfg_lsbfirst_q_i ? wfg_axis_tdata_i[0] : w_aligned[DATA_W-1];
  assign w_rest      = cfg_lsbfirst_q_i ? (wfg_axis_tdata_i >> 1) : (w_aligned << 1);
  assign w_next_bit  = r_lsbfirst ? r_shreg[0] : r_shreg[DATA_W-1];

  // Edges are numbered from 1; an edge produced when r_edges is odd is a
  // trailing edge. The final trailing edge (2N) does not advance sdo.
  assign w_last_edge = {r_nbits, 1'b0};
  assign w_shift     = (r_state == ST_SHIFT) & ctrl_en_q_i & w_tick & r_edges[0] &
                       (r_edges != (w_last_edge - 1'b1));

  wfg_drive_spi_clkdiv u_clkdiv (
    .i_clk        (wb_clk_i),
    .i_rst        (wb_rst_i),
    .i_clr        (w_abort),
    .i_load       (w_accept),
    .i_load_val   (clkcfg_div_q_i),
    .i_run        (w_active),
    .i_reload_val (r_div),
    .o_tick       (w_tick)
  );

  // Frame snapshot and shift register
  always_ff @(posedge wb_clk_i) begin
    if (w_accept) begin
      r_cpol     <= cfg_cpol_q_i;
      r_sspol    <= cfg_sspol_q_i;
      r_lsbfirst <= cfg_lsbfirst_q_i;
      r_div      <= clkcfg_div_q_i;
      r_nbits    <= w_nbits_new;
      r_shreg    <= w_rest;
    end else if (w_shift) begin
      r_shreg    <= r_lsbfirst ? (r_shreg >> 1) : (r_shreg << 1);
    end
  end

  // Frame sequencer with registered pin outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cs        <= 1'b1;
      r_sclk      <= 1'b0;
      r_sdo       <= 1'b0;
      r_underflow <= 1'b0;
      r_overrun   <= 1'b0;
      r_edges     <= '0;
    end else begin
      r_underflow <= 1'b0;
      r_overrun   <= wfg_drive_spi_start_i & w_active;
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_cs    <= ~r_sspol;
        r_sclk  <= r_cpol;
        r_sdo   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Idle levels follow the live configuration
            r_cs   <= ~cfg_sspol_q_i;
            r_sclk <= cfg_cpol_q_i;
            r_sdo  <= 1'b0;
            if (w_accept) begin
              r_state <= ST_SETUP;
              r_cs    <= cfg_sspol_q_i;
              r_sdo   <= w_first_bit;
              r_edges <= '0;
            end else if (wfg_drive_spi_start_i && ctrl_en_q_i) begin
              r_underflow <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (w_tick) begin
              r_sclk  <= ~r_cpol;
              r_edges <= 7'd1;
              r_state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            // Last half-period after the final trailing edge keeps sclk idle
            if (w_tick) begin
              if (r_edges == w_last_edge) begin
                r_state <= ST_HOLD;
              end else begin
                r_sclk  <= ~r_sclk;
                r_edges <= r_edges + 1'b1;
                if (w_shift) begin
                  r_sdo <= w_next_bit;
                end
              end
            end
          end
          ST_HOLD: begin
            if (w_tick) begin
              r_state <= ST_IDLE;
              r_cs    <= ~r_sspol;
              r_sclk  <= r_cpol;
              r_sdo   <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wfg_axis_tready_o = w_accept;
  assign spi_sclk_o        = r_sclk;
  assign spi_cs_o          = r_cs;
  assign spi_sdo_o         = r_sdo;
  assign busy_o            = w_active;
  assign underflow_o       = r_underflow;
  assign overrun_o         = r_overrun;

endmodule
